// File: rtl/itype_alu_pipe.sv
// Two-stage pipelined I-type ALU (ADDI/ORI/XORI/ANDI/SLLI/SRLI/SRAI) with valid/ready on both sides.
// Define ITYPE_ALU_FLAGS_EN to add registered zero/carry/overflow flag outputs.
module itype_alu_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IMM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             addi_en,
    input  logic             ori_en,
    input  logic             xori_en,
    input  logic             andi_en,
    input  logic             slli_en,
    input  logic             srli_en,
    input  logic             srai_en,
    input  logic [XLEN-1:0]  rd_data,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ITYPE_ALU_FLAGS_EN
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
`endif
    output logic [XLEN-1:0]  alu_out,
    output logic             op_err
);

    localparam int unsigned SH_W = $clog2(XLEN);

    localparam logic [6:0] EnAddi = 7'b000_0001;
    localparam logic [6:0] EnOri  = 7'b000_0010;
    localparam logic [6:0] EnXori = 7'b000_0100;
    localparam logic [6:0] EnAndi = 7'b000_1000;
    localparam logic [6:0] EnSlli = 7'b001_0000;
    localparam logic [6:0] EnSrli = 7'b010_0000;
    localparam logic [6:0] EnSrai = 7'b100_0000;

    logic             s1_valid_q, s1_valid_d;
    logic [6:0]       s1_en_q, s1_en_d;
    logic [XLEN-1:0]  s1_rd_q, s1_rd_d;
    logic [IMM_W-1:0] s1_imm_q, s1_imm_d;

    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  alu_out_q, alu_out_d;
    logic             op_err_q, op_err_d;

    logic adv1, adv2, accept, move;
    logic [XLEN-1:0] imm_sx, imm_zx, res;
    logic [SH_W-1:0] shamt;
    logic            res_err;

`ifdef ITYPE_ALU_FLAGS_EN
    logic            flag_z_q, flag_z_d;
    logic            flag_c_q, flag_c_d;
    logic            flag_v_q, flag_v_d;
    logic [XLEN:0]   sum_ext;
`endif

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;
    assign move     = s1_valid_q && adv2;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_en_d    = s1_en_q;
        s1_rd_d    = s1_rd_q;
        s1_imm_d   = s1_imm_q;
        if (adv1) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_en_d  = {srai_en, srli_en, slli_en, andi_en, xori_en, ori_en, addi_en};
            s1_rd_d  = rd_data;
            s1_imm_d = imm;
        end
    end

    // Shifts use the low SH_W bits of the zero-extended immediate; upper bits are ignored.
    always_comb begin
        imm_sx  = XLEN'($signed(s1_imm_q));
        imm_zx  = XLEN'(s1_imm_q);
        shamt   = imm_zx[SH_W-1:0];
        res     = '0;
        res_err = 1'b0;
        case (s1_en_q)
            EnAddi:  res = s1_rd_q + imm_sx;
            EnOri:   res = s1_rd_q | imm_sx;
            EnXori:  res = s1_rd_q ^ imm_sx;
            EnAndi:  res = s1_rd_q & imm_sx;
            EnSlli:  res = s1_rd_q << shamt;
            EnSrli:  res = s1_rd_q >> shamt;
            EnSrai:  res = $signed(s1_rd_q) >>> shamt;
            default: res_err = 1'b1;
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        alu_out_d  = alu_out_q;
        op_err_d   = op_err_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
        end
        // Result registers load only on a real transfer so they hold through stalls and bubbles.
        if (move) begin
            alu_out_d = res;
            op_err_d  = res_err;
        end
    end

`ifdef ITYPE_ALU_FLAGS_EN
    always_comb begin
        sum_ext  = {1'b0, s1_rd_q} + {1'b0, imm_sx};
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        if (move) begin
            flag_z_d = (res == '0);
            flag_c_d = (s1_en_q == EnAddi) && sum_ext[XLEN];
            flag_v_d = (s1_en_q == EnAddi) && (s1_rd_q[XLEN-1] == imm_sx[XLEN-1])
                       && (sum_ext[XLEN-1] != s1_rd_q[XLEN-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_en_q    <= '0;
            s1_rd_q    <= '0;
            s1_imm_q   <= '0;
            s2_valid_q <= 1'b0;
            alu_out_q  <= '0;
            op_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_en_q    <= s1_en_d;
            s1_rd_q    <= s1_rd_d;
            s1_imm_q   <= s1_imm_d;
            s2_valid_q <= s2_valid_d;
            alu_out_q  <= alu_out_d;
            op_err_q   <= op_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign alu_out   = alu_out_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_itype_alu_pipe.sv
// Directed self-checking bench for itype_alu_pipe; flag checks are active when
// ITYPE_ALU_FLAGS_EN is defined.
module tb_itype_alu_pipe;

    localparam logic [6:0] OpAddi = 7'b000_0001;
    localparam logic [6:0] OpOri  = 7'b000_0010;
    localparam logic [6:0] OpXori = 7'b000_0100;
    localparam logic [6:0] OpAndi = 7'b000_1000;
    localparam logic [6:0] OpSlli = 7'b001_0000;
    localparam logic [6:0] OpSrli = 7'b010_0000;
    localparam logic [6:0] OpSrai = 7'b100_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  en_v = '0;
    logic [31:0] rd_data = '0;
    logic [11:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_out;
    logic        op_err;
`ifdef ITYPE_ALU_FLAGS_EN
    logic        flag_z, flag_c, flag_v;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [32:0] got_q[$];

    itype_alu_pipe #(.XLEN(32), .IMM_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addi_en   (en_v[0]),
        .ori_en    (en_v[1]),
        .xori_en   (en_v[2]),
        .andi_en   (en_v[3]),
        .slli_en   (en_v[4]),
        .srli_en   (en_v[5]),
        .srai_en   (en_v[6]),
        .rd_data   (rd_data),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ITYPE_ALU_FLAGS_EN
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
`endif
        .alu_out   (alu_out),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so a valid&&ready seen at negedge transfers next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({op_err, alu_out});
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op and return just after the edge that accepts it.
    task automatic send(input logic [6:0] en, input logic [31:0] rd, input logic [11:0] im);
        bit done = 0;
        en_v     = en;
        rd_data  = rd;
        imm      = im;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            step();
        end
        in_valid = 1'b0;
        en_v     = '0;
        if (!done) check("send_timeout", 33'd0, 33'd1);
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 20 && got_q.size() < n; i++) step();
        check("drain_count", 33'(got_q.size()), 33'(n));
    endtask

    task automatic expect_q(input string tag, input logic [32:0] exp[$]);
        wait_drain(exp.size());
        foreach (exp[i]) begin
            if (got_q.size() > 0) check(tag, got_q.pop_front(), exp[i]);
        end
        got_q.delete();
    endtask

    initial begin
        logic [31:0] held;
        int t0;

        // Reset
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 33'(out_valid), 33'd0);
        check("rst_alu_out", 33'(alu_out), 33'd0);
        check("rst_op_err", 33'(op_err), 33'd0);
        check("rst_in_ready", 33'(in_ready), 33'd1);

        // 1: ADDI latency
        send(OpAddi, 32'd10, 12'd2);
        check("lat_not_early", 33'(out_valid), 33'd0);
        step();
        check("lat_out_valid", 33'(out_valid), 33'd1);
        check("lat_alu_out", 33'(alu_out), 33'd12);
        check("lat_op_err", 33'(op_err), 33'd0);
        expect_q("lat_q", '{33'd12});

        // 2: all ops back-to-back
        t0 = cyc;
        send(OpAddi, 32'd10, 12'd2);
        send(OpOri,  32'd10, 12'd2);
        send(OpXori, 32'd10, 12'd2);
        send(OpAndi, 32'd10, 12'd2);
        send(OpSlli, 32'd10, 12'd2);
        send(OpSrli, 32'd10, 12'd2);
        send(OpSrai, 32'd10, 12'd2);
        check("b2b_cycles", 33'(cyc - t0), 33'd7);
        expect_q("b2b", '{33'd12, 33'd10, 33'd8, 33'd2, 33'd40, 33'd2, 33'd2});

        // 3: sign extension, arithmetic vs logical shift, ignored upper shift bits
        send(OpAddi, 32'd0, 12'hFFF);
        send(OpSrai, 32'h8000_0000, 12'd4);
        send(OpSrli, 32'h8000_0000, 12'd4);
        send(OpSlli, 32'd1, 12'hFE1);
        send(OpAndi, 32'h1234_5678, 12'h800);
        expect_q("edge", '{33'h0_FFFF_FFFF, 33'h0_F800_0000, 33'h0_0800_0000, 33'd2,
                           33'h0_1234_5000});

        // 4: backpressure
        out_ready = 1'b0;
        send(OpAddi, 32'd10, 12'd1);
        send(OpAddi, 32'd10, 12'd2);
        en_v     = OpAddi;
        rd_data  = 32'd10;
        imm      = 12'd3;
        in_valid = 1'b1;
        @(negedge clk);
        held = alu_out;
        check("stall_in_ready", 33'(in_ready), 33'd0);
        check("stall_out_valid", 33'(out_valid), 33'd1);
        check("stall_first", 33'(held), 33'd11);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("stall_hold", 33'(alu_out), 33'(held));
        check("stall_in_ready2", 33'(in_ready), 33'd0);
        step();
        out_ready = 1'b1;
        send(OpAddi, 32'd10, 12'd3);
        expect_q("stall_order", '{33'd11, 33'd12, 33'd13});

        // 5: illegal enable patterns
        send(OpAddi | OpOri, 32'd10, 12'd2);
        send(7'b0, 32'd10, 12'd2);
        send(7'b111_1111, 32'd10, 12'd2);
        send(OpOri, 32'd5, 12'd2);
        expect_q("illegal", '{33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 33'd7});

        // 6: reset with two ops in flight
        out_ready = 1'b0;
        send(OpAddi, 32'd100, 12'd1);
        send(OpAddi, 32'd200, 12'd1);
        rst_n = 1'b0;
        step();
        check("mid_rst_out_valid", 33'(out_valid), 33'd0);
        check("mid_rst_alu_out", 33'(alu_out), 33'd0);
        check("mid_rst_in_ready", 33'(in_ready), 33'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        send(OpXori, 32'hFF, 12'h0F);
        expect_q("post_rst", '{33'h0_0000_00F0});

`ifdef ITYPE_ALU_FLAGS_EN
        send(OpAddi, 32'h7FFF_FFFF, 12'd1);
        step();
        check("ovf_v", 33'(flag_v), 33'd1);
        check("ovf_c", 33'(flag_c), 33'd0);
        check("ovf_z", 33'(flag_z), 33'd0);
        send(OpAddi, 32'hFFFF_FFFF, 12'd1);
        step();
        check("wrap_z", 33'(flag_z), 33'd1);
        check("wrap_c", 33'(flag_c), 33'd1);
        check("wrap_v", 33'(flag_v), 33'd0);
        send(OpOri, 32'hFFFF_FFFF, 12'd1);
        step();
        check("ori_c", 33'(flag_c), 33'd0);
        got_q.delete();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
